// File: rtl/led_band_scan_sequencer.sv
// led_band_scan_sequencer: shifts one angle's LED column out bit by bit, then latches it.
// Optional tick buffering is enabled by defining LED_BAND_SEQ_PENDING_EN.
module led_band_scan_sequencer #(
    parameter int NB_LED_COLUMN = 32,
    parameter int BIT_PER_COLOR = 8,
    parameter int NB_0_LSB = 1,
    parameter int NB_ANGLES = 128,
    parameter int SCLK_DIV = 2,
    parameter int LAT_CYCLES = 4,
    localparam int BW = BIT_PER_COLOR + NB_0_LSB,
    localparam int RW = NB_LED_COLUMN > 1 ? $clog2(NB_LED_COLUMN) : 1,
    localparam int SW = BW > 1 ? $clog2(BW) : 1,
    localparam int AW = NB_ANGLES > 1 ? $clog2(NB_ANGLES) : 1,
    localparam int PW = $clog2(2 * SCLK_DIV),
    localparam int LW = LAT_CYCLES > 1 ? $clog2(LAT_CYCLES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          angle_tick,
    input  logic          index,
    output logic          SCLK,
    output logic          LAT,
    output logic [AW-1:0] angle,
    output logic [RW-1:0] row,
    output logic [1:0]    color,
    output logic [SW-1:0] bit_sel,
    output logic          new_frame,
    output logic          busy,
    output logic          overrun
);
    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t        state, state_n;
    logic [PW-1:0] phase, phase_n;
    logic [LW-1:0] lat_cnt, lat_n;
    logic [RW-1:0] row_n;
    logic [1:0]    color_n;
    logic [SW-1:0] bit_n;
    logic [AW-1:0] angle_n;
    logic          frame_n, seen, seen_n, ovr_n, start;
    logic          last_bit, wrap_phase, exit_latch, tick_busy;

    assign SCLK       = state == SHIFT && phase >= PW'(SCLK_DIV);
    assign LAT        = state == LATCH;
    assign busy       = state != IDLE;
    assign last_bit   = row == '0 && color == 2'd0 && bit_sel == '0;
    assign wrap_phase = phase == PW'(2 * SCLK_DIV - 1);
    assign exit_latch = state == LATCH && lat_cnt == LW'(LAT_CYCLES - 1);
    assign tick_busy  = angle_tick && busy;

`ifdef LED_BAND_SEQ_PENDING_EN
    logic pend, pend_n;
    assign start = angle_tick || pend;
    always_ff @(posedge clk or negedge rst)
        if (!rst) pend <= 1'b0;
        else      pend <= pend_n;
`else
    assign start = angle_tick;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            phase     <= '0;
            lat_cnt   <= '0;
            row       <= RW'(NB_LED_COLUMN - 1);
            color     <= 2'd2;
            bit_sel   <= SW'(BW - 1);
            angle     <= '0;
            new_frame <= 1'b0;
            seen      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            lat_cnt   <= lat_n;
            row       <= row_n;
            color     <= color_n;
            bit_sel   <= bit_n;
            angle     <= angle_n;
            new_frame <= frame_n;
            seen      <= seen_n;
            overrun   <= ovr_n;
        end
    end

    always_comb begin
        state_n = state;
        phase_n = phase;
        lat_n   = lat_cnt;
        row_n   = row;
        color_n = color;
        bit_n   = bit_sel;
        angle_n = angle;
        frame_n = 1'b0;
        seen_n  = seen || index;
`ifdef LED_BAND_SEQ_PENDING_EN
        ovr_n  = overrun || (tick_busy && pend);
        pend_n = pend || tick_busy;
`else
        ovr_n = overrun || tick_busy;
`endif
        case (state)
            IDLE: if (start) begin
                state_n = SHIFT;
                phase_n = '0;
`ifdef LED_BAND_SEQ_PENDING_EN
                pend_n  = 1'b0;
`endif
            end
            SHIFT: begin
                phase_n = wrap_phase ? '0 : phase + 1'b1;
                // bit pointer moves only at phase wrap so data is stable a full low half-period
                if (wrap_phase && last_bit) begin
                    state_n = LATCH;
                    lat_n   = '0;
                    row_n   = RW'(NB_LED_COLUMN - 1);
                    color_n = 2'd2;
                    bit_n   = SW'(BW - 1);
                end else if (wrap_phase) begin
                    bit_n   = bit_sel == '0 ? SW'(BW - 1) : bit_sel - 1'b1;
                    color_n = bit_sel != '0 ? color : color == 2'd0 ? 2'd2 : color - 1'b1;
                    row_n   = (bit_sel == '0 && color == 2'd0) ? row - 1'b1 : row;
                end
            end
            LATCH: begin
                lat_n = lat_cnt + 1'b1;
                if (exit_latch) begin
                    state_n = IDLE;
                    angle_n = (seen || index || angle == AW'(NB_ANGLES - 1)) ? '0 : angle + 1'b1;
                    frame_n = angle_n == '0;
                    seen_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_led_band_scan_sequencer.sv
// tb_led_band_scan_sequencer: randomized scans checked against an arithmetic model of bit order and angle.
module tb_led_band_scan_sequencer;
    localparam int NC = 32, BPC = 8, Z = 1, NA = 8, SD = 2, LC = 4;
    localparam int BW = BPC + Z;
    localparam int TOTAL = NC * 3 * BW;
    localparam int SH = TOTAL * 2 * SD;
    localparam int EXIT = SH + LC - 1;
`ifdef LED_BAND_SEQ_PENDING_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b0, angle_tick = 1'b0, index = 1'b0;
    logic SCLK, LAT, new_frame, busy, overrun;
    logic [2:0] angle;
    logic [4:0] row;
    logic [1:0] color;
    logic [3:0] bit_sel;

    int checks = 0, errors = 0;
    int m_angle = 0;
    bit m_seen = 1'b0, m_pend = 1'b0, m_ovr = 1'b0;

    always #5 clk = ~clk;

    led_band_scan_sequencer #(
        .NB_LED_COLUMN(NC), .BIT_PER_COLOR(BPC), .NB_0_LSB(Z),
        .NB_ANGLES(NA), .SCLK_DIV(SD), .LAT_CYCLES(LC)
    ) dut (
        .clk(clk), .rst(rst), .angle_tick(angle_tick), .index(index),
        .SCLK(SCLK), .LAT(LAT), .angle(angle), .row(row), .color(color),
        .bit_sel(bit_sel), .new_frame(new_frame), .busy(busy), .overrun(overrun)
    );

    task automatic busy_tick_model();
        if (PEND) begin
            if (m_pend) m_ovr = 1'b1;
            else m_pend = 1'b1;
        end else m_ovr = 1'b1;
    endtask

    task automatic pulse_tick();
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk);
        #1 angle_tick = 1'b1;
        @(posedge clk);
        #1 angle_tick = 1'b0;
    endtask

    task automatic scan(input int idx_at, input int t1, input int t2);
        int k, lat, cyc, guard;
        logic prev;
        bit moved;
        logic [4:0] er;
        logic [1:0] ec;
        logic [3:0] eb;
        logic [2:0] ea;
        k = 0; lat = 0; cyc = 0; guard = 0; prev = 1'b0; moved = 1'b0;
        @(negedge clk);
        while (busy !== 1'b1 && guard < 10) begin
            guard++;
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL scan_start: busy=%b expected 1", busy); end
        while (busy === 1'b1 && cyc < SH + LC + 20) begin
            if (SCLK === 1'b1 && prev === 1'b0) begin
                er = 5'(NC - 1 - k / (3 * BW));
                ec = 2'(2 - (k / BW) % 3);
                eb = 4'(BW - 1 - k % BW);
                checks++;
                if ({row, color, bit_sel} !== {er, ec, eb}) begin
                    errors++;
                    $display("FAIL bit_order: pulse %0d row/color/bit=%0d/%0d/%0d expected %0d/%0d/%0d",
                             k, row, color, bit_sel, er, ec, eb);
                end
                k++;
            end
            if (LAT === 1'b1) lat++;
            if (angle !== m_angle[2:0]) moved = 1'b1;
            index = (cyc == idx_at);
            angle_tick = (cyc == t1 || cyc == t2);
            if (cyc == idx_at) m_seen = 1'b1;
            if (angle_tick) busy_tick_model();
            prev = SCLK;
            cyc++;
            @(negedge clk);
        end
        index = 1'b0;
        angle_tick = 1'b0;
        ea = m_seen ? 3'd0 : 3'((m_angle + 1) % NA);
        m_seen = 1'b0;
        m_angle = int'(ea);
        checks++;
        if (k != TOTAL) begin errors++; $display("FAIL sclk_count: got %0d expected %0d", k, TOTAL); end
        checks++;
        if (lat != LC) begin errors++; $display("FAIL lat_width: got %0d expected %0d", lat, LC); end
        checks++;
        if (moved) begin errors++; $display("FAIL angle_stable: angle changed during scan"); end
        checks++;
        if (angle !== ea) begin errors++; $display("FAIL angle_next: got %0d expected %0d", angle, ea); end
        checks++;
        if (new_frame !== (ea == 3'd0)) begin errors++; $display("FAIL new_frame: got %b expected %b", new_frame, ea == 3'd0); end
        checks++;
        if (overrun !== m_ovr) begin errors++; $display("FAIL overrun: got %b expected %b", overrun, m_ovr); end
        checks++;
        if ({SCLK, LAT, row, color, bit_sel} !== {1'b0, 1'b0, 5'(NC - 1), 2'd2, 4'(BW - 1)}) begin
            errors++;
            $display("FAIL idle_state: sclk/lat/row/color/bit=%b/%b/%0d/%0d/%0d expected 0/0/%0d/2/%0d",
                     SCLK, LAT, row, color, bit_sel, NC - 1, BW - 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({SCLK, LAT, busy, new_frame, overrun, angle} !== 8'b0) begin
            errors++;
            $display("FAIL reset_ctrl: sclk/lat/busy/nf/ovr/angle=%b%b%b%b%b/%0d expected 00000/0",
                     SCLK, LAT, busy, new_frame, overrun, angle);
        end
        checks++;
        if ({row, color, bit_sel} !== {5'(NC - 1), 2'd2, 4'(BW - 1)}) begin
            errors++;
            $display("FAIL reset_ptr: row/color/bit=%0d/%0d/%0d expected %0d/2/%0d", row, color, bit_sel, NC - 1, BW - 1);
        end
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_single_scan();
        pulse_tick();
        scan(-1, -1, -1);
    endtask

    task automatic test_overrun();
        bit woke;
        pulse_tick();
        scan(-1, $urandom_range(1, SH - 1), EXIT);
        if (m_pend) begin
            m_pend = 1'b0;
            scan(-1, -1, -1);
        end else begin
            woke = 1'b0;
            repeat (6) begin
                @(negedge clk);
                if (busy !== 1'b0) woke = 1'b1;
            end
            checks++;
            if (woke) begin errors++; $display("FAIL dropped_tick: busy rose, expected no extra scan"); end
        end
    endtask

    task automatic test_index();
        while (m_angle != 5) begin
            pulse_tick();
            scan(-1, -1, -1);
        end
        pulse_tick();
        scan($urandom_range(0, SH - 1), -1, -1);
        pulse_tick();
        scan(-1, -1, -1);
        pulse_tick();
        scan(EXIT, -1, -1);
    endtask

    task automatic test_wrap();
        while (m_angle != NA - 1) begin
            pulse_tick();
            scan(-1, -1, -1);
        end
        pulse_tick();
        scan(-1, -1, -1);
        @(negedge clk);
        checks++;
        if (new_frame !== 1'b0) begin errors++; $display("FAIL frame_width: new_frame=%b expected 0", new_frame); end
    endtask

    task automatic test_reset_mid_scan();
        int k, guard;
        logic prev;
        bit stray;
        k = 0; guard = 0; prev = 1'b0; stray = 1'b0;
        pulse_tick();
        while (k < 100 && guard < 1000) begin
            @(negedge clk);
            if (SCLK === 1'b1 && prev === 1'b0) k++;
            prev = SCLK;
            guard++;
        end
        checks++;
        if (k != 100) begin errors++; $display("FAIL reach_bit100: got %0d pulses expected 100", k); end
        rst = 1'b0;
        #1;
        checks++;
        if ({SCLK, LAT, busy, overrun, angle} !== 7'b0) begin
            errors++;
            $display("FAIL reset_abort: sclk/lat/busy/ovr/angle=%b%b%b%b/%0d expected 0000/0", SCLK, LAT, busy, overrun, angle);
        end
        m_angle = 0; m_seen = 1'b0; m_pend = 1'b0; m_ovr = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (SH + LC + 10) begin
            @(negedge clk);
            if (SCLK !== 1'b0 || LAT !== 1'b0 || busy !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray) begin errors++; $display("FAIL post_reset_quiet: activity seen, expected none"); end
        pulse_tick();
        scan(-1, -1, -1);
    endtask

    initial begin
        test_reset();
        test_single_scan();
        test_overrun();
        test_index();
        test_wrap();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
